// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, sample record and fixed-point helpers for the FFT butterfly datapath.
package fft_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int FFT_TW_W   = 16;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  // Helpers use a 64-bit signed carrier so every intermediate width of the datapath fits.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fft_butterfly_dp_cmul.sv
// fft_cmul: pipeline stage S2, registered complex product P = W*B rounded half-up by TW_W-1 bits.
// A is carried alongside so it stays aligned with its product.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int TW_W   = FFT_TW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [TW_W-1:0]   w_re,
  input  logic [TW_W-1:0]   w_im,
  output logic              out_valid,
  output logic [DATA_W-1:0] a_re_o,
  output logic [DATA_W-1:0] a_im_o,
  output logic [DATA_W+1:0] p_re,
  output logic [DATA_W+1:0] p_im
);

  localparam int MW = DATA_W + TW_W;
  localparam int SW = DATA_W + 2;

  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [MW:0]   pf_re, pf_im;
  logic                 load;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    a_re_q, a_re_d, a_im_q, a_im_d;
  logic [SW-1:0]        p_re_q, p_re_d, p_im_q, p_im_d;

  always_comb begin
    m_rr    = MW'($signed(b_re)) * MW'($signed(w_re));
    m_ii    = MW'($signed(b_im)) * MW'($signed(w_im));
    m_ri    = MW'($signed(b_re)) * MW'($signed(w_im));
    m_ir    = MW'($signed(b_im)) * MW'($signed(w_re));
    pf_re   = (MW+1)'(m_rr) - (MW+1)'(m_ii);
    pf_im   = (MW+1)'(m_ri) + (MW+1)'(m_ir);
    load    = en & in_valid;
    valid_d = en ? in_valid : valid_q;
    a_re_d  = load ? a_re : a_re_q;
    a_im_d  = load ? a_im : a_im_q;
    // Full-scale -1 * -1 rounds to +2^(DATA_W), which still fits in DATA_W+2 signed bits.
    p_re_d  = load ? SW'(round_shr(64'(pf_re), TW_W - 1)) : p_re_q;
    p_im_d  = load ? SW'(round_shr(64'(pf_im), TW_W - 1)) : p_im_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_re_q  <= '0;
      a_im_q  <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
    end else begin
      valid_q <= valid_d;
      a_re_q  <= a_re_d;
      a_im_q  <= a_im_d;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
    end
  end

  assign out_valid = valid_q;
  assign a_re_o    = a_re_q;
  assign a_im_o    = a_im_q;
  assign p_re      = p_re_q;
  assign p_im      = p_im_q;

endmodule

// File: rtl/fft_butterfly_dp.sv
// fft_butterfly_dp: three-stage radix-2 DIT butterfly, X = A + W*B and Y = A - W*B, valid/ready on both sides.
// Define FFT_BFLY_SCALE_EN to halve the S3 sums with round-half-up before saturation.
module fft_butterfly_dp
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int TW_W   = FFT_TW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [TW_W-1:0]   w_re,
  input  logic [TW_W-1:0]   w_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_re,
  output logic [DATA_W-1:0] x_im,
  output logic [DATA_W-1:0] y_re,
  output logic [DATA_W-1:0] y_im,
  input  logic              clr_ovf,
  output logic              ovf
);

  localparam int SW = DATA_W + 2;

  logic en, load1, load3;

  logic              v1_q, v1_d;
  logic [DATA_W-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
  logic [DATA_W-1:0] b1_re_q, b1_re_d, b1_im_q, b1_im_d;
  logic [TW_W-1:0]   w1_re_q, w1_re_d, w1_im_q, w1_im_d;

  logic              v2;
  logic [DATA_W-1:0] a2_re, a2_im;
  logic [SW-1:0]     p2_re, p2_im;

  logic signed [SW-1:0] sum_s [4];
  logic signed [63:0]   scaled [4];
  logic [DATA_W-1:0]    res [4];
  logic                 sat_any;

  logic              v3_q, v3_d;
  logic [DATA_W-1:0] x_re_q, x_re_d, x_im_q, x_im_d;
  logic [DATA_W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  logic              ovf_q, ovf_d;

  // Single global advance: the whole pipe freezes only while a result waits on the consumer.
  assign en = ~v3_q | out_ready;

  always_comb begin
    load1   = en & in_valid;
    v1_d    = en ? in_valid : v1_q;
    a1_re_d = load1 ? a_re : a1_re_q;
    a1_im_d = load1 ? a_im : a1_im_q;
    b1_re_d = load1 ? b_re : b1_re_q;
    b1_im_d = load1 ? b_im : b1_im_q;
    w1_re_d = load1 ? w_re : w1_re_q;
    w1_im_d = load1 ? w_im : w1_im_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_re_q <= '0;
      a1_im_q <= '0;
      b1_re_q <= '0;
      b1_im_q <= '0;
      w1_re_q <= '0;
      w1_im_q <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_re_q <= a1_re_d;
      a1_im_q <= a1_im_d;
      b1_re_q <= b1_re_d;
      b1_im_q <= b1_im_d;
      w1_re_q <= w1_re_d;
      w1_im_q <= w1_im_d;
    end
  end

  fft_cmul #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (v1_q),
    .a_re      (a1_re_q),
    .a_im      (a1_im_q),
    .b_re      (b1_re_q),
    .b_im      (b1_im_q),
    .w_re      (w1_re_q),
    .w_im      (w1_im_q),
    .out_valid (v2),
    .a_re_o    (a2_re),
    .a_im_o    (a2_im),
    .p_re      (p2_re),
    .p_im      (p2_im)
  );

  assign sum_s[0] = SW'($signed(a2_re)) + $signed(p2_re);
  assign sum_s[1] = SW'($signed(a2_im)) + $signed(p2_im);
  assign sum_s[2] = SW'($signed(a2_re)) - $signed(p2_re);
  assign sum_s[3] = SW'($signed(a2_im)) - $signed(p2_im);

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef FFT_BFLY_SCALE_EN
      scaled[i] = round_shr(64'(sum_s[i]), 1);
`else
      scaled[i] = 64'(sum_s[i]);
`endif
      res[i]  = DATA_W'(sat_clamp(scaled[i], DATA_W));
      sat_any = sat_any | sat_hit(scaled[i], DATA_W);
    end
  end

  // A saturation landing in S3 beats a simultaneous clear so no overflow event is lost.
  always_comb begin
    load3  = en & v2;
    v3_d   = en ? v2 : v3_q;
    x_re_d = load3 ? res[0] : x_re_q;
    x_im_d = load3 ? res[1] : x_im_q;
    y_re_d = load3 ? res[2] : y_re_q;
    y_im_d = load3 ? res[3] : y_im_q;
    ovf_d  = (load3 & sat_any) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q   <= 1'b0;
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v3_q   <= v3_d;
      x_re_q <= x_re_d;
      x_im_q <= x_im_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = en & ~rst;
  assign out_valid = v3_q;
  assign x_re      = x_re_q;
  assign x_im      = x_im_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign ovf       = ovf_q;

endmodule
